multicycle_cu: RTL and testbench
================================

// Module: multicycle_cu
// PURPOSE
//  Multi-cycle control FSM sequencing the shared-memory MIPS-subset datapath (single ALU, unified
//  instruction/data memory, IR/MDR/A/B/ALUOut registers). Decodes opcode from IR, drives per-state
//  datapath controls, waits on memory handshake, counts retired instructions. Sits beside datapath top.
// PARAMETERS
//  OPC_W     6   opcode width (IR[31:26])
//  RETIRE_W  16  width of retired-instruction counter (wraps)
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  opc          in   OPC_W    opcode from IR (valid from DECODE onward)
//  zero         in   1        ALU zero flag
//  mem_ready    in   1        memory completes current read/write this cycle
//  pc_write     out  1        unconditional PC load
//  pc_write_cond out 1        PC load if zero (beq)
//  i_or_d       out  1        0: mem addr=PC, 1: mem addr=ALUOut
//  mem_read     out  1        memory read request, held until mem_ready
//  mem_write    out  1        memory write request, held until mem_ready
//  ir_write     out  1        load IR
//  reg_dst      out  1        write reg = rd (1) / rt (0)
//  r31          out  1        write reg = 31 (overrides reg_dst)
//  mem_to_reg   out  1        write data = MDR
//  write_pc_4   out  1        write data = PC (already +4)
//  reg_write    out  1        register file write enable
//  alu_src_a    out  1        0: PC, 1: A
//  alu_src_b    out  2        00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//  alu_op       out  2        00 funct, 01 add, 10 sub, 11 slt
//  pc_src       out  2        00 ALU result, 01 ALUOut, 10 jump addr, 11 A (jr)
//  instr_done   out  1        1-cycle pulse on last state of each instruction
//  retired      out  RETIRE_W retired-instruction count
// BEHAVIOUR
//  - rst: state=START, retired=0; every output 0 while in reset and in START. START->FETCH next cycle.
//  - Outputs are Moore decodes of state, except FETCH ir_write/pc_write and MEM_* completion, gated by mem_ready.
//  - Opcodes: 000000 R, 000001 lw, 000010 sw, 000011 addi, 000100 slti, 000101 j, 000110 jal, 000111 jr, 001000 beq.
//  - FETCH: mem_read=1,i_or_d=0,alu_src_a=0,alu_src_b=01,alu_op=01,pc_src=00; stay while !mem_ready;
//    on mem_ready: ir_write=1,pc_write=1, ->DECODE.
//  - DECODE: alu_src_a=0,alu_src_b=11,alu_op=01 (branch target into ALUOut); dispatch on opc:
//    R->EXEC_R; lw/sw->MEM_ADR; addi/slti->EXEC_I; beq->BRANCH; j->JUMP; jal->JAL; jr->JR; other->ILLEGAL path.
//  - EXEC_R: a=1,b=00,op=00 ->R_WB: reg_dst=1,reg_write=1,done.
//  - EXEC_I: a=1,b=10,op=01(addi)/11(slti) ->I_WB: reg_write=1,done.
//  - MEM_ADR: a=1,b=10,op=01; lw->MEM_RD, sw->MEM_WR.
//  - MEM_RD: mem_read=1,i_or_d=1; wait mem_ready ->LW_WB: mem_to_reg=1,reg_write=1,done.
//  - MEM_WR: mem_write=1,i_or_d=1; wait mem_ready; done on mem_ready cycle ->FETCH.
//  - BRANCH: a=1,b=00,op=10,pc_src=01,pc_write_cond=1,done. JUMP: pc_src=10,pc_write=1,done.
//  - JAL: pc_src=10,pc_write=1,r31=1,write_pc_4=1,reg_write=1,done. JR: pc_src=11,pc_write=1,done.
//  - Every done state ->FETCH; retired increments on instr_done, wraps at 2^RETIRE_W.
//  - Latency (mem_ready always 1): beq/j/jal/jr 3, R/addi/slti/sw 4, lw 5 cycles.
//  - mem_read and mem_write never both 1; mem_write only in MEM_WR; reg_write never with pc_write_cond.
//  - rst mid-instruction: immediate START, no partial write completes after rst rises.
// CONFIGURATION
//  MCU_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE ->HALT; HALT drives all controls 0, adds output
//    illegal_op=1, stays until rst; retired not incremented.
//  Undefined: unknown opcode treated as NOP: DECODE ->FETCH with instr_done=1 (retired increments);
//    illegal_op port absent.
// STRUCTURE
//  mcu_pkg: opcode localparams, state encoding, ALU_OP_*, ALU_B_*, PC_SRC_* codes.
//  Sub-module mcu_opc_decode: combinational opc -> one-hot instruction class (incl. illegal);
//    FSM and counter in multicycle_cu.
// TESTING
//  - rst=1 mid-lw (in MEM_RD) -> all outputs 0 same cycle; after release START, FETCH; retired=0.
//  - mem_ready=1 always, addi then R add -> 4 cycles each, reg_write pulses in I_WB/R_WB, retired=2.
//  - lw with mem_ready low 3 cycles in FETCH and 2 in MEM_RD -> 10 cycles total, mem_read held high throughout.
//  - beq zero=1 then zero=0 -> pc_write_cond=1,pc_src=01 in BRANCH both times, 3 cycles each.
//  - jal -> JAL cycle: r31=1,write_pc_4=1,reg_write=1,pc_src=10; jr -> pc_src=11,pc_write=1.
//  - opc=6'b111111 -> trap build: HALT, illegal_op=1, retired unchanged; NOP build: FETCH after DECODE, retired+1.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode values,
// instruction-class indices, FSM state encoding, datapath mux/ALU codes and
// the bundled control word driven by the FSM output decode.
package mcu_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b000001;
    localparam logic [5:0] OP_SW   = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b000011;
    localparam logic [5:0] OP_SLTI = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000101;
    localparam logic [5:0] OP_JAL  = 6'b000110;
    localparam logic [5:0] OP_JR   = 6'b000111;
    localparam logic [5:0] OP_BEQ  = 6'b001000;

    // Bit positions in the one-hot instruction class vector
    localparam int CLS_R    = 0;
    localparam int CLS_LW   = 1;
    localparam int CLS_SW   = 2;
    localparam int CLS_ADDI = 3;
    localparam int CLS_SLTI = 4;
    localparam int CLS_J    = 5;
    localparam int CLS_JAL  = 6;
    localparam int CLS_JR   = 7;
    localparam int CLS_BEQ  = 8;
    localparam int CLS_ILL  = 9;
    localparam int CLS_W    = 10;

    localparam logic [1:0] ALU_OP_FUNCT = 2'b00;
    localparam logic [1:0] ALU_OP_ADD   = 2'b01;
    localparam logic [1:0] ALU_OP_SUB   = 2'b10;
    localparam logic [1:0] ALU_OP_SLT   = 2'b11;

    localparam logic [1:0] ALU_B_REG    = 2'b00;
    localparam logic [1:0] ALU_B_FOUR   = 2'b01;
    localparam logic [1:0] ALU_B_IMM    = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_A      = 2'b11;

    typedef enum logic [3:0] {
        S_START   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_R_WB    = 4'd4,
        S_EXEC_I  = 4'd5,
        S_I_WB    = 4'd6,
        S_MEM_ADR = 4'd7,
        S_MEM_RD  = 4'd8,
        S_LW_WB   = 4'd9,
        S_MEM_WR  = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_JAL     = 4'd13,
        S_JR      = 4'd14,
        S_HALT    = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       r31;
        logic       mem_to_reg;
        logic       write_pc_4;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_cu_if.sv
// Control-unit <-> datapath bundle.
//   opc, zero, mem_ready      : datapath -> control unit
//   datapath controls, instr_done, retired : control unit -> datapath
//   illegal_op                : present only when MCU_ILLEGAL_TRAP_EN is defined
// modport master = control unit, modport slave = datapath side.
interface multicycle_cu_if #(
    parameter int OPC_W    = 6,
    parameter int RETIRE_W = 16
);
    logic [OPC_W-1:0]    opc;
    logic                zero;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                r31;
    logic                mem_to_reg;
    logic                write_pc_4;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_src;
    logic                instr_done;
    logic [RETIRE_W-1:0] retired;
`ifdef MCU_ILLEGAL_TRAP_EN
    logic                illegal_op;
`endif

    modport master (
        input  opc, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, r31, mem_to_reg, write_pc_4, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_src, instr_done, retired
`ifdef MCU_ILLEGAL_TRAP_EN
        , illegal_op
`endif
    );

    modport slave (
        output opc, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, r31, mem_to_reg, write_pc_4, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_src, instr_done, retired
`ifdef MCU_ILLEGAL_TRAP_EN
        , illegal_op
`endif
    );
endinterface

// File: rtl/mcu_opc_decode.sv
// Combinational opcode decoder.
//   opc : opcode from IR
//   cls : one-hot instruction class (CLS_* positions); unknown opcodes set CLS_ILL
module mcu_opc_decode
    import mcu_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opc,
    output logic [CLS_W-1:0] cls
);

    always_comb begin
        cls = '0;
        case (opc)
            OPC_W'(OP_R):    cls[CLS_R]    = 1'b1;
            OPC_W'(OP_LW):   cls[CLS_LW]   = 1'b1;
            OPC_W'(OP_SW):   cls[CLS_SW]   = 1'b1;
            OPC_W'(OP_ADDI): cls[CLS_ADDI] = 1'b1;
            OPC_W'(OP_SLTI): cls[CLS_SLTI] = 1'b1;
            OPC_W'(OP_J):    cls[CLS_J]    = 1'b1;
            OPC_W'(OP_JAL):  cls[CLS_JAL]  = 1'b1;
            OPC_W'(OP_JR):   cls[CLS_JR]   = 1'b1;
            OPC_W'(OP_BEQ):  cls[CLS_BEQ]  = 1'b1;
            default:         cls[CLS_ILL]  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control FSM for the shared-memory MIPS-subset datapath, plus
// retired-instruction counter.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : multicycle_cu_if.master (opc/zero/mem_ready in, controls out)
// Build option MCU_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in HALT and
// raise illegal_op; without it they retire as a NOP straight from DECODE.
//
// state   | meaning
// --------+-----------------------------------------------------------
// START   | post-reset idle cycle, all controls low
// FETCH   | read instruction at PC, PC+4; waits on mem_ready
// DECODE  | branch target into ALUOut, dispatch on opcode
// EXEC_R  | A op B (funct)
// R_WB    | write rd
// EXEC_I  | A + / slt sext imm
// I_WB    | write rt
// MEM_ADR | A + sext imm -> ALUOut
// MEM_RD  | data read at ALUOut; waits on mem_ready
// LW_WB   | write MDR to rt
// MEM_WR  | data write at ALUOut; retires on mem_ready
// BRANCH  | A - B, PC <= ALUOut if zero
// JUMP    | PC <= jump address
// JAL     | PC <= jump address, r31 <= PC
// JR      | PC <= A
// HALT    | illegal opcode trap, held until reset (trap build only)
module multicycle_cu
    import mcu_pkg::*;
#(
    parameter int OPC_W    = 6,
    parameter int RETIRE_W = 16
) (
    input logic            clk,
    input logic            rst,
    multicycle_cu_if.master bus
);

    state_t              state;
    state_t              state_nxt;
    ctrl_t               ctrl;
    logic [CLS_W-1:0]    cls;
    logic [RETIRE_W-1:0] retired;

    mcu_opc_decode #(.OPC_W(OPC_W)) u_opc_decode (
        .opc (bus.opc),
        .cls (cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_START;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_START:  state_nxt = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (cls[CLS_R])                        state_nxt = S_EXEC_R;
                else if (cls[CLS_LW] || cls[CLS_SW])   state_nxt = S_MEM_ADR;
                else if (cls[CLS_ADDI] || cls[CLS_SLTI]) state_nxt = S_EXEC_I;
                else if (cls[CLS_BEQ])                 state_nxt = S_BRANCH;
                else if (cls[CLS_J])                   state_nxt = S_JUMP;
                else if (cls[CLS_JAL])                 state_nxt = S_JAL;
                else if (cls[CLS_JR])                  state_nxt = S_JR;
`ifdef MCU_ILLEGAL_TRAP_EN
                else                                   state_nxt = S_HALT;
`else
                else                                   state_nxt = S_FETCH;
`endif
            end
            S_EXEC_R:  state_nxt = S_R_WB;
            S_EXEC_I:  state_nxt = S_I_WB;
            S_MEM_ADR: state_nxt = cls[CLS_LW] ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (bus.mem_ready) state_nxt = S_LW_WB;
            S_MEM_WR:  if (bus.mem_ready) state_nxt = S_FETCH;
            S_R_WB, S_I_WB, S_LW_WB,
            S_BRANCH, S_JUMP, S_JAL, S_JR: state_nxt = S_FETCH;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_START;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALU_B_IMM_SH;
                ctrl.alu_op    = ALU_OP_ADD;
`ifndef MCU_ILLEGAL_TRAP_EN
                // unknown opcode retires here as a NOP
                ctrl.instr_done = cls[CLS_ILL];
`endif
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = cls[CLS_SLTI] ? ALU_OP_SLT : ALU_OP_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_LW_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = bus.mem_ready;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALU_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_src        = PC_SRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src     = PC_SRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl.pc_src     = PC_SRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.r31        = 1'b1;
                ctrl.write_pc_4 = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JR: begin
                ctrl.pc_src     = PC_SRC_A;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (ctrl.instr_done) begin
            retired <= retired + RETIRE_W'(1);
        end
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.r31           = ctrl.r31;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.write_pc_4    = ctrl.write_pc_4;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.instr_done    = ctrl.instr_done;
    assign bus.retired       = retired;
`ifdef MCU_ILLEGAL_TRAP_EN
    assign bus.illegal_op    = (state == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: reset behaviour, per-instruction latency,
// key control outputs on the retiring cycle, memory wait handling, mid-
// instruction reset and illegal-opcode handling (trap or NOP build).
module tb_multicycle_cu;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multicycle_cu_if #(.OPC_W(6), .RETIRE_W(16)) bus ();

    multicycle_cu #(.OPC_W(6), .RETIRE_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // snapshot of the retiring cycle and per-instruction activity counts
    logic       d_reg_write, d_reg_dst, d_mem_to_reg, d_r31, d_wpc4;
    logic       d_pc_write, d_pc_write_cond;
    logic [1:0] d_pc_src;
    int         rw_cnt, mr_cnt, mw_cnt;
    int         excl_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] outs_vec();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.reg_dst, bus.r31,
                bus.mem_to_reg, bus.write_pc_4, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_src, bus.instr_done};
    endfunction

    // Called #1 after a rising edge in FETCH; returns with the next
    // instruction's first cycle current. fw/mw = wait cycles in FETCH / MEM_*.
    task automatic run_instr(input logic [5:0] op, input logic z,
                             input int fw, input int mw, output int cyc);
        int  fc = 0;
        int  mc = 0;
        logic seen = 1'b0;
        bus.opc  = op;
        bus.zero = z;
        cyc = 0; rw_cnt = 0; mr_cnt = 0; mw_cnt = 0;
        while (!seen && cyc < 40) begin
            if (bus.mem_read && !bus.i_or_d) begin
                bus.mem_ready = (fc >= fw); fc++;
            end else if ((bus.mem_read || bus.mem_write) && bus.i_or_d) begin
                bus.mem_ready = (mc >= mw); mc++;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1;
            cyc++;
            if (bus.reg_write) rw_cnt++;
            if (bus.mem_read)  mr_cnt++;
            if (bus.mem_write) mw_cnt++;
            if ((bus.mem_read && bus.mem_write) || (bus.reg_write && bus.pc_write_cond))
                excl_bad++;
            if (bus.instr_done) begin
                seen = 1'b1;
                d_reg_write = bus.reg_write;   d_reg_dst = bus.reg_dst;
                d_mem_to_reg = bus.mem_to_reg; d_r31 = bus.r31;
                d_wpc4 = bus.write_pc_4;       d_pc_write = bus.pc_write;
                d_pc_write_cond = bus.pc_write_cond; d_pc_src = bus.pc_src;
            end
            @(posedge clk); #1;
        end
        chk("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    int cyc;

    initial begin
        bus.opc = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {13'd0, outs_vec()}, 32'd0);
        chk("rst_retired", {16'd0, bus.retired}, 32'd0);
        rst = 1'b0;
        #1;
        chk("start_outs", {13'd0, outs_vec()}, 32'd0);
        @(posedge clk); #1;
        chk("fetch_mem_read", {31'd0, bus.mem_read}, 32'd1);
        chk("fetch_alu", {28'd0, bus.alu_src_b, bus.alu_op}, 32'b0101);
        chk("fetch_ir_write", {31'd0, bus.ir_write}, 32'd1);

        run_instr(6'b000011, 1'b0, 0, 0, cyc);   // addi
        chk("addi_cyc", cyc, 4);
        chk("addi_rw_cnt", rw_cnt, 1);
        chk("addi_rw_done", {31'd0, d_reg_write}, 32'd1);

        run_instr(6'b000000, 1'b0, 0, 0, cyc);   // R
        chk("r_cyc", cyc, 4);
        chk("r_reg_dst", {31'd0, d_reg_dst}, 32'd1);
        chk("r_rw_cnt", rw_cnt, 1);
        chk("retired_2", {16'd0, bus.retired}, 32'd2);

        run_instr(6'b000001, 1'b0, 3, 2, cyc);   // lw with waits
        chk("lw_wait_cyc", cyc, 10);
        chk("lw_mem_read_cnt", mr_cnt, 7);
        chk("lw_mem_to_reg", {31'd0, d_mem_to_reg}, 32'd1);
        chk("retired_3", {16'd0, bus.retired}, 32'd3);

        run_instr(6'b001000, 1'b1, 0, 0, cyc);   // beq taken
        chk("beq1_cyc", cyc, 3);
        chk("beq1_pwc", {31'd0, d_pc_write_cond}, 32'd1);
        chk("beq1_pc_src", {30'd0, d_pc_src}, 32'd1);
        run_instr(6'b001000, 1'b0, 0, 0, cyc);   // beq not taken
        chk("beq0_cyc", cyc, 3);
        chk("beq0_pwc", {31'd0, d_pc_write_cond}, 32'd1);
        chk("beq0_pc_src", {30'd0, d_pc_src}, 32'd1);

        run_instr(6'b000110, 1'b0, 0, 0, cyc);   // jal
        chk("jal_cyc", cyc, 3);
        chk("jal_ctl", {28'd0, d_r31, d_wpc4, d_reg_write, d_pc_write}, 32'b1111);
        chk("jal_pc_src", {30'd0, d_pc_src}, 32'd2);

        run_instr(6'b000111, 1'b0, 0, 0, cyc);   // jr
        chk("jr_cyc", cyc, 3);
        chk("jr_pc_src", {30'd0, d_pc_src}, 32'd3);
        chk("jr_pc_write", {31'd0, d_pc_write}, 32'd1);

        run_instr(6'b000010, 1'b0, 0, 0, cyc);   // sw
        chk("sw_cyc", cyc, 4);
        chk("sw_mem_write_cnt", mw_cnt, 1);
        chk("sw_rw_cnt", rw_cnt, 0);

        run_instr(6'b000101, 1'b0, 0, 0, cyc);   // j
        chk("j_cyc", cyc, 3);
        chk("j_pc_src", {30'd0, d_pc_src}, 32'd2);
        chk("retired_9", {16'd0, bus.retired}, 32'd9);
        chk("excl_violations", excl_bad, 0);

        // reset in the middle of a stalled lw data read
        bus.opc = 6'b000001; bus.mem_ready = 1'b1;
        @(posedge clk); #1;                      // DECODE
        @(posedge clk); #1;                      // MEM_ADR
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;                      // MEM_RD
        chk("memrd_addr", {30'd0, bus.mem_read, bus.i_or_d}, 32'b11);
        rst = 1'b1;
        #1;
        chk("midrst_outs", {13'd0, outs_vec()}, 32'd0);
        chk("midrst_retired", {16'd0, bus.retired}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_ready = 1'b1;
        #1;
        chk("midrst_start", {13'd0, outs_vec()}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_fetch", {30'd0, bus.mem_read, bus.i_or_d}, 32'b10);

`ifdef MCU_ILLEGAL_TRAP_EN
        bus.opc = 6'b111111;
        @(posedge clk); #1;                      // DECODE
        chk("ill_decode_flag", {31'd0, bus.illegal_op}, 32'd0);
        @(posedge clk); #1;                      // HALT
        chk("ill_flag", {31'd0, bus.illegal_op}, 32'd1);
        chk("ill_outs", {13'd0, outs_vec()}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ill_held", {31'd0, bus.illegal_op}, 32'd1);
        chk("ill_retired", {16'd0, bus.retired}, 32'd0);
`else
        run_instr(6'b111111, 1'b0, 0, 0, cyc);
        chk("nop_cyc", cyc, 2);
        chk("nop_retired", {16'd0, bus.retired}, 32'd1);
        chk("nop_next_fetch", {30'd0, bus.mem_read, bus.i_or_d}, 32'b10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
